csr_trap_unit: RTL and testbench

//  Responder for the system/CSR instructions decoded by the controller. Holds user-level trap CSRs,

---
 rtl/csr_pkg.sv | 22 ++
 rtl/csr_trap_unit_if.sv | 38 +++
 rtl/irq_pending.sv | 34 +++
 rtl/csr_trap_unit.sv | 169 ++++++++++++++++
 tb/tb_csr_trap_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the user-level trap CSR unit: CSR addresses,
// cause codes, ustatus bit positions and the redirect FSM encoding.
package csr_pkg;

  localparam logic [11:0] ADDR_USTATUS = 12'h000;
  localparam logic [11:0] ADDR_UIE     = 12'h004;
  localparam logic [11:0] ADDR_UTVEC   = 12'h005;
  localparam logic [11:0] ADDR_UEPC    = 12'h041;
  localparam logic [11:0] ADDR_UCAUSE  = 12'h042;
  localparam logic [11:0] ADDR_UIP     = 12'h044;

  localparam int CAUSE_ECALL = 8;

  localparam int UIE_BIT  = 0;
  localparam int UPIE_BIT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Commit-stage bundle between the controller (master) and the CSR/trap unit (slave).
interface csr_trap_unit_if #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 3
);
  logic [NIRQ-1:0]  irq;
  logic             wb_valid;
  logic [WIDTH-1:0] wb_pc;
  logic [WIDTH-1:0] wb_next_pc;
  logic             ecall;
  logic             uret;
  logic             CSRRW;
  logic             CSRRS;
  logic             CSRRC;
  logic             CSRRWI;
  logic             CSRRSI;
  logic             CSRRCI;
  logic [11:0]      csr_addr;
  logic [WIDTH-1:0] rs1_val;
  logic [4:0]       zimm;
  logic [WIDTH-1:0] csr_rdata;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  modport master (
    output irq, wb_valid, wb_pc, wb_next_pc, ecall, uret,
           CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
           csr_addr, rs1_val, zimm,
    input  csr_rdata, redirect, redirect_pc
  );

  modport slave (
    input  irq, wb_valid, wb_pc, wb_next_pc, ecall, uret,
           CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
           csr_addr, rs1_val, zimm,
    output csr_rdata, redirect, redirect_pc
  );
endinterface

// File: rtl/irq_pending.sv
// Rising-edge detection of the level irq lines into uip, with a software
// write path; a new edge on a bit wins over a simultaneous clear of it.
module irq_pending #(
  parameter int NIRQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            we,
  input  logic [NIRQ-1:0] wdata,
  output logic [NIRQ-1:0] uip
);

  logic [NIRQ-1:0] irq_q, irq_d;
  logic [NIRQ-1:0] uip_q, uip_d;

  always_comb begin
    irq_d = irq;
    uip_d = (we ? wdata : uip_q) | (irq & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
      uip_q <= '0;
    end else begin
      irq_q <= irq_d;
      uip_q <= uip_d;
    end
  end

  assign uip = uip_q;

endmodule

// File: rtl/csr_trap_unit.sv
// User-level trap CSRs and commit-time CSR/ecall/uret/interrupt handling,
// issuing a registered one-cycle redirect toward the trap target.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NIRQ     = 3,
  parameter logic [WIDTH-1:0] TVEC_RST = '0
) (
  input logic             clk,
  input logic             rst,
  csr_trap_unit_if.slave  bus
);

  state_e           state_q;
  logic             redirect_q;
  logic [WIDTH-1:0] redirect_pc_q;

  logic             uie_bit_q, uie_bit_d;
  logic             upie_q, upie_d;
  logic [NIRQ-1:0]  uie_q, uie_d;
  logic [WIDTH-1:0] utvec_q, utvec_d;
  logic [WIDTH-1:0] uepc_q, uepc_d;
  logic [WIDTH-1:0] ucause_q, ucause_d;
  logic [NIRQ-1:0]  uip;

  logic             commit, is_iform, csr_op, csr_we, uip_we;
  logic [WIDTH-1:0] src, rdata, wdata, tgt;
  logic             take_ecall, take_uret, take_irq, take_trap;
  logic [NIRQ-1:0]  irq_pend;
  logic [WIDTH-2:0] irq_idx;

  assign commit   = bus.wb_valid && (state_q == ST_IDLE);
  assign is_iform = bus.CSRRWI | bus.CSRRSI | bus.CSRRCI;
  assign csr_op   = bus.CSRRW | bus.CSRRS | bus.CSRRC | is_iform;
  assign src      = is_iform ? WIDTH'(bus.zimm) : bus.rs1_val;
  // Set/clear forms with a zero source are pure reads and must not write.
  assign csr_we   = commit && csr_op && (bus.CSRRW || bus.CSRRWI || (src != '0));
  assign uip_we   = csr_we && (bus.csr_addr == ADDR_UIP);

  always_comb begin
    rdata = '0;
    case (bus.csr_addr)
      ADDR_USTATUS: begin
        rdata[UIE_BIT]  = uie_bit_q;
        rdata[UPIE_BIT] = upie_q;
      end
      ADDR_UIE:     rdata = WIDTH'(uie_q);
      ADDR_UTVEC:   rdata = utvec_q;
      ADDR_UEPC:    rdata = uepc_q;
      ADDR_UCAUSE:  rdata = ucause_q;
      ADDR_UIP:     rdata = WIDTH'(uip);
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    if (bus.CSRRW || bus.CSRRWI)      wdata = src;
    else if (bus.CSRRS || bus.CSRRSI) wdata = rdata | src;
    else                              wdata = rdata & ~src;
  end

  // Interrupt eligibility uses the pre-write UIE, so a write clearing UIE still traps.
  assign irq_pend   = uip & uie_q;
  assign take_ecall = commit && bus.ecall;
  assign take_uret  = commit && !bus.ecall && bus.uret;
  assign take_irq   = commit && !bus.ecall && !bus.uret && uie_bit_q && (|irq_pend);
  assign take_trap  = take_ecall || take_uret || take_irq;
  assign tgt        = take_uret ? uepc_q : utvec_q;

  always_comb begin
    irq_idx = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (irq_pend[i]) irq_idx = (WIDTH-1)'(i);
    end
  end

  always_comb begin
    uie_bit_d = uie_bit_q;
    upie_d    = upie_q;
    uie_d     = uie_q;
    utvec_d   = utvec_q;
    uepc_d    = uepc_q;
    ucause_d  = ucause_q;
    if (csr_we) begin
      case (bus.csr_addr)
        ADDR_USTATUS: begin
          uie_bit_d = wdata[UIE_BIT];
          upie_d    = wdata[UPIE_BIT];
        end
        ADDR_UIE:    uie_d    = wdata[NIRQ-1:0];
        ADDR_UTVEC:  utvec_d  = wdata;
        ADDR_UEPC:   uepc_d   = wdata;
        ADDR_UCAUSE: ucause_d = wdata;
        default: ;
      endcase
    end
    // Trap side effects are applied after the CSR write so they take precedence.
    if (take_ecall) begin
      uepc_d    = bus.wb_pc;
      ucause_d  = WIDTH'(CAUSE_ECALL);
      upie_d    = uie_bit_q;
      uie_bit_d = 1'b0;
    end else if (take_uret) begin
      uie_bit_d = upie_q;
      upie_d    = 1'b1;
    end else if (take_irq) begin
      uepc_d    = bus.wb_next_pc;
      ucause_d  = {1'b1, irq_idx};
      upie_d    = uie_bit_q;
      uie_bit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uie_bit_q <= 1'b0;
      upie_q    <= 1'b0;
      uie_q     <= '0;
      utvec_q   <= TVEC_RST;
      uepc_q    <= '0;
      ucause_q  <= '0;
    end else begin
      uie_bit_q <= uie_bit_d;
      upie_q    <= upie_d;
      uie_q     <= uie_d;
      utvec_q   <= utvec_d;
      uepc_q    <= uepc_d;
      ucause_q  <= ucause_d;
    end
  end

  // REDIR lasts exactly one cycle; the instruction committing during it is being flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          redirect_q <= take_trap;
          if (take_trap) begin
            state_q       <= ST_REDIR;
            redirect_pc_q <= tgt;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  irq_pending #(.NIRQ(NIRQ)) u_irq_pending (
    .clk   (clk),
    .rst   (rst),
    .irq   (bus.irq),
    .we    (uip_we),
    .wdata (wdata[NIRQ-1:0]),
    .uip   (uip)
  );

  assign bus.csr_rdata   = rdata;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR access, ecall/uret, prioritised
// interrupts, pending-bit races and reset during a redirect.
module tb_csr_trap_unit;
  import csr_pkg::*;

  localparam int          W    = 32;
  localparam int          N    = 3;
  localparam logic [31:0] TVEC = 32'h0000_0200;

  localparam int OP_RW = 0, OP_RS = 1, OP_RC = 2, OP_RWI = 3, OP_RSI = 4, OP_RCI = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_trap_unit_if #(.WIDTH(W), .NIRQ(N)) ifc ();

  csr_trap_unit #(.WIDTH(W), .NIRQ(N), .TVEC_RST(TVEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ifc.wb_valid   = 1'b0;
    ifc.wb_pc      = '0;
    ifc.wb_next_pc = '0;
    ifc.ecall      = 1'b0;
    ifc.uret       = 1'b0;
    ifc.CSRRW      = 1'b0;
    ifc.CSRRS      = 1'b0;
    ifc.CSRRC      = 1'b0;
    ifc.CSRRWI     = 1'b0;
    ifc.CSRRSI     = 1'b0;
    ifc.CSRRCI     = 1'b0;
    ifc.csr_addr   = '0;
    ifc.rs1_val    = '0;
    ifc.zimm       = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    ifc.wb_valid = 1'b0;
    ifc.csr_addr = a;
    #1;
    chk(tag, ifc.csr_rdata, exp);
  endtask

  task automatic csr(input string tag, input int op, input logic [11:0] a,
                     input logic [31:0] s, input logic [31:0] exp_old);
    clr_in();
    ifc.wb_valid = 1'b1;
    ifc.csr_addr = a;
    ifc.rs1_val  = s;
    ifc.zimm     = s[4:0];
    case (op)
      OP_RW:   ifc.CSRRW  = 1'b1;
      OP_RS:   ifc.CSRRS  = 1'b1;
      OP_RC:   ifc.CSRRC  = 1'b1;
      OP_RWI:  ifc.CSRRWI = 1'b1;
      OP_RSI:  ifc.CSRRSI = 1'b1;
      default: ifc.CSRRCI = 1'b1;
    endcase
    #1;
    chk(tag, ifc.csr_rdata, exp_old);
    tick();
    clr_in();
  endtask

  task automatic sys(input logic e, input logic u, input logic [31:0] pc, input logic [31:0] npc);
    clr_in();
    ifc.wb_valid   = 1'b1;
    ifc.ecall      = e;
    ifc.uret       = u;
    ifc.wb_pc      = pc;
    ifc.wb_next_pc = npc;
    tick();
    clr_in();
  endtask

  initial begin
    clr_in();
    ifc.irq = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 5; i++) begin
      chk("rst_redirect", {31'b0, ifc.redirect}, 32'h0);
      tick();
    end
    rd("rst_ustatus", ADDR_USTATUS, 32'h0);
    rd("rst_uie",     ADDR_UIE,     32'h0);
    rd("rst_utvec",   ADDR_UTVEC,   TVEC);
    rd("rst_uepc",    ADDR_UEPC,    32'h0);
    rd("rst_ucause",  ADDR_UCAUSE,  32'h0);
    rd("rst_uip",     ADDR_UIP,     32'h0);
    rd("rst_unimpl",  12'h123,      32'h0);

    // Basic CSR writes
    csr("rw_utvec_old", OP_RW, ADDR_UTVEC, 32'h100, TVEC);
    rd("utvec_new", ADDR_UTVEC, 32'h100);
    csr("rsi_ustatus_old", OP_RSI, ADDR_USTATUS, 32'h1, 32'h0);
    rd("ustatus_uie", ADDR_USTATUS, 32'h1);
    csr("rs_zero_src", OP_RS, ADDR_UTVEC, 32'h0, 32'h100);
    rd("utvec_kept", ADDR_UTVEC, 32'h100);

    // ecall
    sys(1'b1, 1'b0, 32'h40, 32'h44);
    chk("ecall_redirect", {31'b0, ifc.redirect}, 32'h1);
    chk("ecall_tgt", ifc.redirect_pc, 32'h100);
    tick();
    chk("ecall_pulse_end", {31'b0, ifc.redirect}, 32'h0);
    rd("ecall_uepc",    ADDR_UEPC,    32'h40);
    rd("ecall_ucause",  ADDR_UCAUSE,  32'h8);
    rd("ecall_ustatus", ADDR_USTATUS, 32'h10);

    // uret, with an ecall arriving during REDIR
    csr("rw_uepc_old", OP_RW, ADDR_UEPC, 32'h44, 32'h40);
    sys(1'b0, 1'b1, 32'h50, 32'h54);
    chk("uret_redirect", {31'b0, ifc.redirect}, 32'h1);
    chk("uret_tgt", ifc.redirect_pc, 32'h44);
    sys(1'b1, 1'b0, 32'h80, 32'h84);
    chk("redir_ecall_ignored", {31'b0, ifc.redirect}, 32'h0);
    rd("uret_uepc_kept",   ADDR_UEPC,    32'h44);
    rd("uret_ucause_kept", ADDR_UCAUSE,  32'h8);
    rd("uret_ustatus",     ADDR_USTATUS, 32'h11);

    // Interrupts: irq0 and irq2 together, highest index first
    csr("rwi_uie_old", OP_RWI, ADDR_UIE, 32'h7, 32'h0);
    ifc.irq = 3'b101;
    tick();
    rd("uip_set", ADDR_UIP, 32'h5);
    sys(1'b0, 1'b0, 32'h60, 32'h64);
    chk("irq2_redirect", {31'b0, ifc.redirect}, 32'h1);
    chk("irq2_tgt", ifc.redirect_pc, 32'h100);
    tick();
    rd("irq2_ucause",  ADDR_UCAUSE,  32'h8000_0002);
    rd("irq2_uepc",    ADDR_UEPC,    32'h64);
    rd("irq2_ustatus", ADDR_USTATUS, 32'h10);
    rd("irq2_uip",     ADDR_UIP,     32'h5);
    csr("rc_uip_old", OP_RC, ADDR_UIP, 32'h4, 32'h5);
    rd("uip_after_clr", ADDR_UIP, 32'h1);
    sys(1'b0, 1'b1, 32'h68, 32'h6c);
    chk("uret2_tgt", ifc.redirect_pc, 32'h64);
    tick();
    rd("uret2_ustatus", ADDR_USTATUS, 32'h11);
    sys(1'b0, 1'b0, 32'h70, 32'h74);
    chk("irq0_redirect", {31'b0, ifc.redirect}, 32'h1);
    tick();
    rd("irq0_ucause", ADDR_UCAUSE, 32'h8000_0000);
    rd("irq0_uepc",   ADDR_UEPC,   32'h74);

    // ecall wins over a pending interrupt; the interrupt follows after uret
    csr("rci_uip_old", OP_RCI, ADDR_UIP, 32'h1, 32'h1);
    ifc.irq = 3'b000;
    tick();
    csr("rsi_uie_old", OP_RSI, ADDR_USTATUS, 32'h1, 32'h10);
    ifc.irq = 3'b010;
    tick();
    rd("uip_irq1", ADDR_UIP, 32'h2);
    sys(1'b1, 1'b0, 32'h90, 32'h94);
    chk("ecall_pri_tgt", ifc.redirect_pc, 32'h100);
    tick();
    rd("ecall_pri_ucause", ADDR_UCAUSE, 32'h8);
    rd("ecall_pri_uepc",   ADDR_UEPC,   32'h90);
    rd("ecall_pri_uip",    ADDR_UIP,    32'h2);
    sys(1'b0, 1'b1, 32'h98, 32'h9c);
    chk("uret3_tgt", ifc.redirect_pc, 32'h90);
    tick();
    sys(1'b0, 1'b0, 32'hA0, 32'hA4);
    chk("irq1_redirect", {31'b0, ifc.redirect}, 32'h1);
    tick();
    rd("irq1_ucause", ADDR_UCAUSE, 32'h8000_0001);
    rd("irq1_uepc",   ADDR_UEPC,   32'hA4);

    // Edge during a clear of the same uip bit: set wins
    ifc.irq = 3'b000;
    tick();
    ifc.irq = 3'b010;
    csr("rci_race_old", OP_RCI, ADDR_UIP, 32'h2, 32'h2);
    rd("uip_race", ADDR_UIP, 32'h2);

    // Reset during REDIR
    ifc.irq = 3'b000;
    sys(1'b1, 1'b0, 32'hB0, 32'hB4);
    chk("pre_rst_redirect", {31'b0, ifc.redirect}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_redir_drop", {31'b0, ifc.redirect}, 32'h0);
    rd("rst2_ustatus", ADDR_USTATUS, 32'h0);
    rd("rst2_utvec",   ADDR_UTVEC,   TVEC);
    rd("rst2_uepc",    ADDR_UEPC,    32'h0);
    rd("rst2_uip",     ADDR_UIP,     32'h0);
    tick();
    chk("rst2_redirect_idle", {31'b0, ifc.redirect}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
